vr_rr_arbiter: RTL and testbench



---
 rtl/vr_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 28 ++
 rtl/vr_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_vr_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_arb_pkg.sv
// Shared types and helpers for the valid/ready round-robin arbiter.
package vr_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first requester strictly after ptr, wrapping.
module rr_pick
  import vr_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [SW-1:0] grant_o,
  output logic          any_req_o
);

  always_comb begin
    logic [SW-1:0] cand;
    grant_o   = '0;
    any_req_o = 1'b0;
    cand      = SW'(rr_next(32'(ptr_i), N));
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_req_o && req_i[cand]) begin
        grant_o   = cand;
        any_req_o = 1'b1;
      end
      cand = SW'(rr_next(32'(cand), N));
    end
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Packet-locking round-robin arbiter merging NUM_REQ valid/ready sources into
// one registered, source-tagged output stage.
module vr_rr_arbiter
  import vr_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = 8,
  localparam int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  output logic [SRC_W-1:0]                out_src,
  output logic                            out_last,
  input  logic                            out_ready
);

  arb_state_t        state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [SRC_W-1:0]  lock_id_q, lock_id_d;
  logic              rst_done_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic              out_last_q, out_last_d;

  logic [SRC_W-1:0]  pick_gnt, grant;
  logic              pick_any, load, xfer, xfer_last;

  rr_pick #(
    .N  (NUM_REQ),
    .SW (SRC_W)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .grant_o   (pick_gnt),
    .any_req_o (pick_any)
  );

  // req_ready is one-hot at grant, so the transfer reduces to a single lookup.
  always_comb begin
    load      = out_ready | ~out_valid_q;
    grant     = (state_q == LOCK) ? lock_id_q : pick_gnt;
    req_ready = '0;
    if (rst_done_q && load && (state_q == LOCK || pick_any)) begin
      req_ready[grant] = 1'b1;
    end
    xfer      = req_valid[grant] & req_ready[grant];
    xfer_last = req_last[grant];

    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      case (state_q)
        ARB: begin
          if (xfer_last) begin
            ptr_d = grant;
          end else begin
            state_d   = LOCK;
            lock_id_d = grant;
          end
        end
        LOCK: begin
          if (xfer_last) begin
            state_d = ARB;
            ptr_d   = lock_id_q;
          end
        end
        default: state_d = ARB;
      endcase
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = req_data[grant];
        out_src_d  = grant;
        out_last_d = xfer_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ARB;
      ptr_q       <= SRC_W'(NUM_REQ - 1);
      lock_id_q   <= '0;
      rst_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_id_q   <= lock_id_d;
      rst_done_q  <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Scoreboard bench for vr_rr_arbiter: per-source beat queues drive requests,
// expected output beats are queued in hand-computed order and popped by a monitor.
module tb_vr_rr_arbiter;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    int unsigned gap;
  } beat_t;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_last;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [1:0]       out_src;
  logic             out_last;
  logic             out_ready;

  beat_t srcq[4][$];
  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;

  vr_rr_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic send(input int src, input logic [7:0] data, input logic last, input int unsigned gap);
    beat_t b;
    exp_t  e;
    b.data = data; b.last = last; b.gap = gap;
    srcq[src].push_back(b);
    e.src = 2'(src); e.data = data; e.last = last;
    expq.push_back(e);
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) return;
    end
    chk("idle_timeout", 32'(expq.size()), 32'd0);
  endtask

  // Requester model: presents each queued beat after its gap, holds it until accepted.
  initial begin
    logic [3:0]  fire;
    logic [3:0]  active;
    int unsigned cnt[4];
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    active    = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    forever begin
      @(negedge clk); #2;
      fire = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && rstn && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          active[i] = 1'b0;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
        end
        if (srcq[i].size() == 0) begin
          active[i] = 1'b0;
          cnt[i]    = 0;
        end else if (!active[i]) begin
          active[i] = 1'b1;
          cnt[i]    = srcq[i][0].gap;
        end
        req_valid[i] = active[i] && cnt[i] == 0;
        req_data[i]  = active[i] ? srcq[i][0].data : 8'h00;
        req_last[i]  = active[i] ? srcq[i][0].last : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted output beat and checks hold stability.
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic [1:0] ps;
    logic       pl;
    exp_t       e;
    pv = 1'b0; pd = '0; ps = '0; pl = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rstn) begin
        pv = 1'b0;
      end else begin
        if (pv) chk("hold_stable", {21'd0, out_valid, out_data, out_src, out_last},
                    {21'd0, 1'b1, pd, ps, pl});
        pv = out_valid && !out_ready;
        pd = out_data; ps = out_src; pl = out_last;
        if (out_valid && out_ready) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got src=%0d data=%h last=%b, want none",
                     out_src, out_data, out_last);
          end else begin
            e = expq.pop_front();
            if ({out_src, out_data, out_last} !== e) begin
              errors++;
              $display("FAIL beat: got src=%0d data=%h last=%b, want src=%0d data=%h last=%b",
                       out_src, out_data, out_last, e.src, e.data, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    int  gaps;
    bit  seen_f1, seen_f3, found;
    rstn      = 1'b0;
    out_ready = 1'b1;

    // Reset with every source requesting, then a full single-beat rotation twice.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) send(i, 8'(16 * (r + 1) + i), 1'b1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    #1 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk("first_out_src", {30'd0, out_src}, 32'd0);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end
    wait_idle(20);

    // 3-beat packet on source 1 with source 2 waiting behind the lock.
    send(1, 8'hA1, 1'b0, 0);
    send(1, 8'hA2, 1'b0, 0);
    send(1, 8'hA3, 1'b1, 0);
    send(2, 8'hB2, 1'b1, 0);
    for (int c = 0; c < 30 && (expq.size() != 0 || out_valid); c++) begin
      @(negedge clk);
      if (out_valid && out_src == 2'd1 && !out_last)
        chk("lock_blocks_src2", 32'(req_ready[2]), 32'd0);
    end
    wait_idle(20);

    // Backpressure: hold out_ready low for three cycles on a valid beat.
    #1 out_ready = 1'b0;
    send(3, 8'hD0, 1'b1, 0);
    send(0, 8'hE0, 1'b1, 0);
    send(3, 8'hD1, 1'b1, 0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = out_valid;
    end
    chk("bp_out_seen", 32'(found), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_data_hold", 32'(out_data), 32'hD0);
      chk("bp_src_hold", {30'd0, out_src}, 32'd3);
      chk("bp_ready_zero", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'hE0);
    wait_idle(20);

    // Locked source 1 drops valid for 2 cycles while source 3 requests.
    send(1, 8'hF1, 1'b0, 0);
    send(1, 8'hF2, 1'b0, 2);
    send(1, 8'hF3, 1'b1, 0);
    send(3, 8'h33, 1'b1, 0);
    gaps = 0; seen_f1 = 0; seen_f3 = 0;
    for (int c = 0; c < 30 && !seen_f3; c++) begin
      @(negedge clk);
      if (out_valid && out_data == 8'hF1) seen_f1 = 1;
      if (out_valid && out_data == 8'hF3) seen_f3 = 1;
      if (seen_f1 && !seen_f3 && !out_valid) begin
        gaps++;
        chk("gap_lock_ready", 32'(req_ready), 32'b0010);
      end
    end
    chk("gap_cycles", 32'(gaps), 32'd2);
    wait_idle(20);

    // Reset in the middle of a locked packet from source 2.
    send(2, 8'h71, 1'b0, 0);
    send(2, 8'h72, 1'b0, 0);
    send(2, 8'h73, 1'b1, 0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = out_valid && out_src == 2'd2;
    end
    chk("lockrst_seen", 32'(found), 32'd1);
    #3 rstn = 1'b0;
    #1;
    chk("lockrst_valid", 32'(out_valid), 32'd0);
    chk("lockrst_data", 32'(out_data), 32'd0);
    chk("lockrst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    send(2, 8'h82, 1'b1, 0);
    send(1, 8'h81, 1'b1, 0);
    // Source 1 wins first from the reset pointer; the swapped push keeps the queue in order.
    expq.delete();
    begin
      exp_t e;
      e.src = 2'd1; e.data = 8'h81; e.last = 1'b1; expq.push_back(e);
      e.src = 2'd2; e.data = 8'h82; e.last = 1'b1; expq.push_back(e);
    end
    @(negedge clk);
    #1 rstn = 1'b1;
    wait_idle(20);

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
